// File: rtl/prog_loader.sv
// Boot-time program loader: takes a byte stream (2-byte word count, then
// big-endian words), writes the words to memory from address 0, then
// releases the processor through cpu_run.
//
// state | meaning
// ------+--------------------------------------------------------------
// HDR0  | waiting for word-count high byte (reset state)
// HDR1  | waiting for word-count low byte, then length check
// DATA  | assembling the current word one byte per accept
// WRITE | single-cycle memory write of the assembled word
// DONE  | program loaded, cpu_run high, stream refused
// ERR   | header length too large for memory, stream refused
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  localparam int BPW    = DATA_W / 8;
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BPW - 1);
  localparam logic [31:0] N_MAX = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t              state;
  logic [15:0]         n_words;
  logic [ADDR_W:0]     widx;
  logic [BCNT_W-1:0]   bcnt;
  logic [DATA_W-1:0]   shreg;

  logic                accept;
  logic [15:0]         n_full;
  logic [DATA_W-1:0]   sh_next;
  logic [ADDR_W:0]     widx_next;

  // Byte-accept decode and next-value helpers; in_ready depends on state only.
  assign in_ready  = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign accept    = in_valid && in_ready;
  assign n_full    = {n_words[15:8], in_data};
  assign sh_next   = (shreg << 8) | DATA_W'(in_data);
  assign widx_next = widx + (ADDR_W + 1)'(1);

  // Loader FSM with registered outputs; the write address/data are captured
  // on the accept of a word's last byte so they are valid during WRITE and
  // then hold until the next write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR0;
      n_words   <= '0;
      widx      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR0: begin
          if (accept) begin
            n_words[15:8] <= in_data;
            state         <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_words[7:0] <= in_data;
            if (n_full == 16'd0) begin
              state   <= DONE;
              cpu_run <= 1'b1;
            end else if (32'(n_full) > N_MAX) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              widx  <= '0;
              bcnt  <= '0;
              busy  <= 1'b1;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shreg <= sh_next;
            bcnt  <= bcnt + BCNT_W'(1);
            if (bcnt == BCNT_LAST) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx[ADDR_W-1:0];
              mem_wdata <= sh_next;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          widx <= widx_next;
          bcnt <= '0;
          if (32'(widx_next) == 32'(n_words)) begin
            busy    <= 1'b0;
            cpu_run <= 1'b1;
            state   <= DONE;
          end else begin
            state <= DATA;
          end
        end
        DONE: ;
        ERR:  ;
        default: state <= HDR0;
      endcase
    end
  end

endmodule
